// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
//   Shared types and defaults for the external asynchronous SRAM controller.
//   - state_e      : controller FSM states
//   - *_DEF        : default geometry and strobe timing
//   - max3()       : helper used to size the shared wait counter
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

  localparam int unsigned AW_DEF      = 18;
  localparam int unsigned DW_DEF      = 16;
  localparam int unsigned RD_WAIT_DEF = 2;
  localparam int unsigned WR_WAIT_DEF = 2;
  localparam int unsigned TURN_DEF    = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SU,
    S_WR_PW,
    S_WR_HD,
    S_TURN
  } state_e;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_dq_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_dq_bus_ctrl_if
//   Request/response handshake between the cache refill/writeback path
//   (master) and the SRAM controller (slave).
//   req_valid/req_ready : transfer on valid & ready
//   req_we              : 1 = write, 0 = read
//   req_addr/req_wdata  : word address and write data
//   rsp_valid           : one-cycle pulse, rsp_rdata valid
//   rsp_rdata           : read data, held until the next read completes
// ---------------------------------------------------------------------------
interface sram_dq_bus_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_dq_iobuf.sv
// ---------------------------------------------------------------------------
// sram_dq_iobuf
//   The single tristate driver for the SRAM data bus.
//   oe   : drive pad with dout when 1, release (high-Z) when 0
//   dout : data driven onto the pad
//   din  : pad value as seen by the core
//   pad  : bidirectional SRAM data pins
// ---------------------------------------------------------------------------
module sram_dq_iobuf
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic          oe,
  input  logic [DW-1:0] dout,
  output logic [DW-1:0] din,
  inout  wire  [DW-1:0] pad
);

  assign pad = oe ? dout : 'z;
  assign din = pad;

endmodule

// File: rtl/sram_dq_bus_ctrl.sv
// ---------------------------------------------------------------------------
// sram_dq_bus_ctrl
//   Single-master controller for an asynchronous SRAM on a shared
//   bidirectional data bus. Sequences ce_n/oe_n/we_n, owns the only bus
//   driver (through sram_dq_iobuf) and inserts turnaround after reads.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   bus        : request/response handshake (slave side)
//   sram_addr  : registered word address
//   sram_dq    : shared data bus
//   sram_ce_n  : chip enable (active low)
//   sram_oe_n  : output enable (active low)
//   sram_we_n  : write enable (active low)
//   dq_oe      : internal drive enable of sram_dq
// ---------------------------------------------------------------------------
module sram_dq_bus_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned RD_WAIT = RD_WAIT_DEF,
  parameter int unsigned WR_WAIT = WR_WAIT_DEF,
  parameter int unsigned TURN    = TURN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_dq_bus_ctrl_if.slave    bus,
  output logic [AW-1:0]        sram_addr,
  inout  wire  [DW-1:0]        sram_dq,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic                 dq_oe
);

  localparam int unsigned CW = $clog2(max3(RD_WAIT, WR_WAIT, TURN) + 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          ready_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] wdata_q;
  logic [AW-1:0] addr_q;
  logic          ce_n_q;
  logic          oe_n_q;
  logic          we_n_q;
  logic          dq_oe_q;
  logic [DW-1:0] dq_in;

  // Every strobe is assigned on the edge that enters the state it belongs
  // to, so all pad-side outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid && ready_q) begin
            ready_q <= 1'b0;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            ce_n_q  <= 1'b0;
            if (bus.req_we) begin
              state_q <= S_WR_SU;
              dq_oe_q <= 1'b1;
            end else begin
              state_q <= S_RD;
              oe_n_q  <= 1'b0;
              cnt_q   <= CW'(RD_WAIT - 1);
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_RD: begin
          if (cnt_q == '0) begin
            rdata_q     <= dq_in;
            rsp_valid_q <= 1'b1;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            cnt_q       <= CW'(TURN - 1);
            state_q     <= S_TURN;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_TURN: begin
          if (cnt_q == '0) begin
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_WR_SU: begin
          we_n_q  <= 1'b0;
          cnt_q   <= CW'(WR_WAIT - 1);
          state_q <= S_WR_PW;
        end
        S_WR_PW: begin
          if (cnt_q == '0) begin
            we_n_q  <= 1'b1;
            state_q <= S_WR_HD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_WR_HD: begin
          ce_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          ready_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  sram_dq_iobuf #(.DW(DW)) u_iobuf (
    .oe   (dq_oe_q),
    .dout (wdata_q),
    .din  (dq_in),
    .pad  (sram_dq)
  );

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign sram_addr     = addr_q;
  assign sram_ce_n     = ce_n_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_we_n     = we_n_q;
  assign dq_oe         = dq_oe_q;

endmodule
